// File: rtl/norm_pkg.sv
// Shared constants, state encoding and helpers for the iterative left normalizer.
package norm_pkg;
    localparam int DW = 32;
    localparam int AW = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Search stage k shifts by 2^k; k counts 4 down to 0.
    function automatic logic [AW:0] step_width(input logic [2:0] k);
        case (k)
            3'd4:    step_width = 6'd16;
            3'd3:    step_width = 6'd8;
            3'd2:    step_width = 6'd4;
            3'd1:    step_width = 6'd2;
            default: step_width = 6'd1;
        endcase
    endfunction

    function automatic logic no_sig_bits(input logic [DW-1:0] d, input logic signed_mode);
        no_sig_bits = (d == '0) || (signed_mode && (d == '1));
    endfunction
endpackage

// File: rtl/norm_iter_if.sv
// Start/ready/done handshake and result bus of the normalizer.
interface norm_iter_if;
    import norm_pkg::*;

    logic          start;
    logic [DW-1:0] d;
    logic          signed_mode;
    logic          ready;
    logic          busy;
    logic          done;
    logic [AW-1:0] sa;
    logic [DW-1:0] sh;
    logic          zero;

    modport master (output start, d, signed_mode,
                    input  ready, busy, done, sa, sh, zero);
    modport slave  (input  start, d, signed_mode,
                    output ready, busy, done, sa, sh, zero);
endinterface

// File: rtl/norm_step.sv
// One binary-search stage: test the top 2^k bits (plus sign in signed mode) and shift if redundant.
module norm_step
    import norm_pkg::*;
(
    input  logic [DW-1:0] w,
    input  logic [2:0]    k,
    input  logic          signed_mode,
    output logic          hit,
    output logic [DW-1:0] w_next
);
    logic [AW:0]   n;
    logic [AW:0]   test_shift;
    logic [DW-1:0] x;

    always_comb begin
        n = step_width(k);
        // Folding the sign into x leaves x[DW-1]=0, so signed mode tests n bits below the sign.
        x = signed_mode ? (w ^ {DW{w[DW-1]}}) : w;
        test_shift = 6'(DW) - n - {5'd0, signed_mode};
        hit = ((x >> test_shift) == '0);
        w_next = hit ? (w << n) : w;
    end
endmodule

// File: rtl/norm_iter.sv
// Iterative normalizer: one search stage per cycle, 5 RUN cycles, one-cycle done pulse.
module norm_iter
    import norm_pkg::*;
(
    input  logic        clk,
    input  logic        clrn,
    norm_iter_if.slave  bus
);
    state_t        state, state_nxt;
    logic [2:0]    k;
    logic [DW-1:0] w;
    logic [AW-1:0] sa;
    logic          mode;
    logic          zero_pend;
    logic          zero;
    logic          done;
    logic          hit;
    logic [DW-1:0] w_next;
    logic          accept;

    norm_step u_step (
        .w           (w),
        .k           (k),
        .signed_mode (mode),
        .hit         (hit),
        .w_next      (w_next)
    );

    assign bus.ready = (state == IDLE) || (state == DONE);
    assign bus.busy  = (state == RUN);
    assign bus.done  = done;
    assign bus.sa    = sa;
    assign bus.sh    = w;
    assign bus.zero  = zero;
    assign accept    = bus.ready && bus.start;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (bus.start) state_nxt = RUN;
            RUN:        if (k == 3'd0) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            k         <= '0;
            w         <= '0;
            sa        <= '0;
            mode      <= 1'b0;
            zero_pend <= 1'b0;
            zero      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state == RUN) && (k == 3'd0);
            if (accept) begin
                w         <= bus.d;
                mode      <= bus.signed_mode;
                sa        <= '0;
                k         <= 3'd4;
                zero_pend <= no_sig_bits(bus.d, bus.signed_mode);
                zero      <= 1'b0;
            end else if (state == RUN) begin
                if (hit) begin
                    w  <= w_next;
                    sa <= sa | (AW'(1) << k);
                end
                if (k != 3'd0) k <= k - 3'd1;
                else           zero <= zero_pend;
            end
        end
    end
endmodule

// File: tb/tb_norm_iter.sv
// Self-checking bench for norm_iter: directed spec cases, back-to-back, mid-run reset, random regression.
module tb_norm_iter;
    logic clk;
    logic clrn;
    int   tests;
    int   fails;

    norm_iter_if bus();

    norm_iter dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: count leading zeros (unsigned) or redundant sign bits (signed), capped at 31.
    function automatic void ref_norm(input logic [31:0] d, input logic m,
                                     output logic [4:0] sa, output logic [31:0] sh, output logic z);
        int c;
        c = 0;
        if (!m) begin
            for (int i = 31; i >= 0; i--) begin
                if (d[i] != 1'b0) break;
                c++;
            end
            z = (d == 32'h0);
        end else begin
            for (int i = 30; i >= 0; i--) begin
                if (d[i] != d[31]) break;
                c++;
            end
            z = (d == 32'h0) || (d == 32'hFFFF_FFFF);
        end
        if (c > 31) c = 31;
        sa = c[4:0];
        sh = d << c;
    endfunction

    // Called at #1 after a rising edge while ready; returns once done is seen or the budget expires.
    task automatic run_op(input logic [31:0] d, input logic m, output int lat, output bit busy_ok);
        bus.start = 1'b1;
        bus.d = d;
        bus.signed_mode = m;
        lat = 0;
        busy_ok = 1'b1;
        do begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) bus.start = 1'b0;
            if (lat <= 5 && !(bus.busy === 1'b1 && bus.ready === 1'b0)) busy_ok = 1'b0;
        end while (!(bus.done === 1'b1) && lat < 20);
    endtask

    task automatic test_reset();
        clrn = 1'b0;
        bus.start = 1'b0;
        bus.d = 32'h0;
        bus.signed_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({bus.ready, bus.busy, bus.done, bus.sa, bus.sh, bus.zero} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: ready=%b busy=%b done=%b sa=%0d sh=%h zero=%b, want ready=1 others 0",
                     bus.ready, bus.busy, bus.done, bus.sa, bus.sh, bus.zero);
        end
        clrn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] dv  [6] = '{32'h0001_0000, 32'h0, 32'h8000_0000, 32'hFFFF_0000, 32'h1, 32'hFFFF_FFFF};
        logic        mv  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [4:0]  esa [6] = '{5'd15, 5'd31, 5'd0, 5'd15, 5'd30, 5'd31};
        logic [31:0] esh [6] = '{32'h8000_0000, 32'h0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h8000_0000};
        logic        ez  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        int lat;
        bit bok;
        for (int i = 0; i < 6; i++) begin
            run_op(dv[i], mv[i], lat, bok);
            tests++;
            if (lat != 6 || !bok) begin
                fails++;
                $display("FAIL directed_latency[%0d]: done at cycle %0d busy_ok=%b, want cycle 6 busy_ok=1", i, lat, bok);
            end
            tests++;
            if ({bus.sa, bus.sh, bus.zero} !== {esa[i], esh[i], ez[i]}) begin
                fails++;
                $display("FAIL directed_result[%0d] d=%h m=%b: sa=%0d sh=%h zero=%b, want sa=%0d sh=%h zero=%b",
                         i, dv[i], mv[i], bus.sa, bus.sh, bus.zero, esa[i], esh[i], ez[i]);
            end
            // Results hold and done drops one cycle later.
            @(posedge clk); #1;
            tests++;
            if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.sa !== esa[i] || bus.sh !== esh[i] || bus.zero !== ez[i]) begin
                fails++;
                $display("FAIL directed_hold[%0d]: done=%b ready=%b sa=%0d sh=%h zero=%b, want done=0 ready=1 results held",
                         i, bus.done, bus.ready, bus.sa, bus.sh, bus.zero);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bus.start = 1'b1;
        bus.d = 32'h0000_FFFF;
        bus.signed_mode = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (bus.done !== 1'b1) begin
                bus.d = $urandom;
                bus.signed_mode = 1'($urandom);
            end
        end while (!(bus.done === 1'b1) && lat < 20);
        tests++;
        if (lat != 6 || bus.sa !== 5'd16 || bus.sh !== 32'hFFFF_0000 || bus.ready !== 1'b1) begin
            fails++;
            $display("FAIL b2b_first: cycle %0d sa=%0d sh=%h ready=%b, want cycle 6 sa=16 sh=ffff0000 ready=1",
                     lat, bus.sa, bus.sh, bus.ready);
        end
        bus.d = 32'h00FF_0000;
        bus.signed_mode = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        tests++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_no_gap: busy=%b done=%b after start on done cycle, want busy=1 done=0", bus.busy, bus.done);
        end
        lat = 1;
        while (!(bus.done === 1'b1) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if (lat != 6 || bus.sa !== 5'd8 || bus.sh !== 32'hFF00_0000) begin
            fails++;
            $display("FAIL b2b_second: cycle %0d sa=%0d sh=%h, want cycle 6 sa=8 sh=ff000000", lat, bus.sa, bus.sh);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_run_reset();
        int lat;
        bit bok;
        bit saw_done;
        logic [4:0] rsa;
        logic [31:0] rsh;
        logic rz;
        bus.start = 1'b1;
        bus.d = 32'h0001_0000;
        bus.signed_mode = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        clrn = 1'b0;
        #1;
        tests++;
        if ({bus.ready, bus.busy, bus.done, bus.sa, bus.sh, bus.zero} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0}) begin
            fails++;
            $display("FAIL midrun_reset_clear: ready=%b busy=%b done=%b sa=%0d sh=%h zero=%b, want ready=1 others 0",
                     bus.ready, bus.busy, bus.done, bus.sa, bus.sh, bus.zero);
        end
        @(posedge clk); #1;
        clrn = 1'b1;
        saw_done = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) saw_done = 1'b1;
        end
        tests++;
        if (saw_done) begin
            fails++;
            $display("FAIL midrun_no_done: activity seen after aborted op, want idle with done=0");
        end
        run_op(32'h0000_0300, 1'b0, lat, bok);
        ref_norm(32'h0000_0300, 1'b0, rsa, rsh, rz);
        tests++;
        if (lat != 6 || {bus.sa, bus.sh, bus.zero} !== {rsa, rsh, rz}) begin
            fails++;
            $display("FAIL midrun_recover: cycle %0d sa=%0d sh=%h zero=%b, want cycle 6 sa=%0d sh=%h zero=%b",
                     lat, bus.sa, bus.sh, bus.zero, rsa, rsh, rz);
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic m;
        logic [4:0] rsa;
        logic [31:0] rsh;
        logic rz;
        int lat;
        bit bok;
        bit norm_ok;
        for (int i = 0; i < 10000; i++) begin
            m = 1'($urandom);
            d = $urandom;
            case ($urandom_range(0, 9))
                0:       d = m ? 32'hFFFF_FFFF : 32'h0;
                1:       d = 32'h0;
                default: d = m ? 32'($signed(d) >>> $urandom_range(0, 31)) : (d >> $urandom_range(0, 31));
            endcase
            ref_norm(d, m, rsa, rsh, rz);
            run_op(d, m, lat, bok);
            tests++;
            if (lat != 6 || !bok || {bus.sa, bus.sh, bus.zero} !== {rsa, rsh, rz} || bus.sh !== (d << bus.sa)) begin
                fails++;
                $display("FAIL random[%0d] d=%h m=%b: lat=%0d sa=%0d sh=%h zero=%b, want lat=6 sa=%0d sh=%h zero=%b",
                         i, d, m, lat, bus.sa, bus.sh, bus.zero, rsa, rsh, rz);
            end
            norm_ok = rz ? 1'b1 : (m ? (bus.sh[31] != bus.sh[30]) : (bus.sh[31] == 1'b1));
            tests++;
            if (!norm_ok) begin
                fails++;
                $display("FAIL random_normalized[%0d] d=%h m=%b: sh=%h not normalized", i, d, m, bus.sh);
            end
        end
        bus.start = 1'b0;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_mid_run_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/norm_iter.md
Name: norm_iter

Overview:
- Multi-cycle left normalizer for the integer/shift datapath. It is the inverse of the barrel shifter: given a value, it recovers the left-shift amount that normalizes it, and returns the shifted value.
- Supports two modes: unsigned (count leading zeros) and signed (count redundant sign bits).
- Uses one binary-search stage per clock (16, 8, 4, 2, 1), driven by a start/ready/done handshake from the ALU control FSM.

Parameters:
- DW, 32, data width; fixed at 32 in this revision (must be a power of 2).
- AW, 5, shift-amount width, log2(DW).

Ports:
- clk  in  1  system clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when ready=1.
- d  in  32  operand, captured on an accepted start.
- signed_mode  in  1  0 = leading-zero normalize; 1 = redundant-sign normalize. Captured with d.
- ready  out  1  unit can accept start (state IDLE or DONE).
- busy  out  1  iteration in progress (state RUN).
- done  out  1  one-cycle pulse; results are valid from this cycle.
- sa  out  5  normalize shift amount.
- sh  out  32  normalized value, d << sa.
- zero  out  1  operand had no significant bits: d==0 (unsigned), or d==0 or d==0xFFFFFFFF (signed).

Behaviour:
- Reset (clrn=0, asynchronous): state=IDLE; ready=1; busy=0; done=0; sa=0; sh=0; zero=0; all internal registers cleared.
- States:
  - IDLE: ready=1.
  - RUN: busy=1, ready=0; step counter k runs 4 down to 0.
  - DONE: ready=1; done=1 only in the first DONE cycle.
- Transitions:
  - IDLE or DONE, start=1: capture d into the working register w and capture mode; clear sa; k=4; go to RUN.
  - RUN, each cycle, using n = 2^k:
    - unsigned: if w[31:32-n] == 0, then w <= w << n and sa[k] <= 1.
    - signed: if w[31:31-n] is all equal to w[31], then w <= w << n and sa[k] <= 1.
    - Otherwise w and sa[k] are unchanged.
    - Then k <= k-1. After the k=0 step, go to DONE.
  - DONE with no start: stay in DONE; done drops after one cycle; sa, sh and zero hold.
- Latency: start accepted in cycle 0; RUN occupies cycles 1..5; done=1 in cycle 6.
  - Throughput is one operation per 6 cycles.
  - start in the same cycle as done is accepted, with no bubble.
- sh is w in DONE. The invariant sh == d << sa must hold for every operand.
- zero is computed from the captured operand at capture time and registered into DONE.
- Zero and all-sign operands:
  - unsigned d==0: every step shifts, giving sa=31, sh=0, zero=1.
  - signed d==0: sa=31, sh=0, zero=1.
  - signed d==0xFFFFFFFF: sa=31, sh=0x80000000, zero=1.
- Already normalized operands:
  - unsigned d[31]=1: sa=0, sh=d.
  - signed d[31]!=d[30]: sa=0, sh=d.
- start while busy=1 is ignored. Operand and mode changes during RUN have no effect.
- Reset asserted mid-RUN aborts the operation; no done pulse is produced.
- Outputs are registered only; no combinational path from inputs to outputs.

Decomposition:
- Shared package norm_pkg:
  - DW and AW constants.
  - State encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Step-width lookup: 16, 8, 4, 2, 1 indexed by k.
- Sub-module norm_step (combinational, one search stage):
  - Inputs: w, k, signed_mode.
  - Outputs: hit, w_next.
  - It is instantiated once and reused every RUN cycle. The top level holds the FSM, counter and registers.

Test Plan:
- unsigned d=0x00010000, start pulse -> done in cycle 6; sa=15, sh=0x80000000, zero=0; busy high in cycles 1..5.
- unsigned d=0x00000000 -> sa=31, sh=0x00000000, zero=1. Unsigned d=0x80000000 -> sa=0, sh=0x80000000.
- signed d=0xFFFF0000 -> sa=15, sh=0x80000000. Signed d=0x00000001 -> sa=30, sh=0x40000000. Signed d=0xFFFFFFFF -> sa=31, sh=0x80000000, zero=1.
- Back-to-back: start held high with d=0x0000FFFF, then 0x00FF0000 presented on the done cycle -> second op accepted with no gap, results sa=16 then sa=8. Starts during busy are ignored, and the result matches the first operand.
- clrn pulsed low in cycle 3 of RUN -> outputs clear immediately; no done pulse; next start completes normally.
- Random regression, 10k operands in both modes -> sh == d << sa; sh[31]=1 (unsigned, nonzero) or sh[31]!=sh[30] (signed, non-all-sign).
